irq_pend_arbiter: RTL
=====================

// Module: irq_pend_arbiter
// PURPOSE
//  Upstream stage of the 16-to-4 encoder.
//  - Captures 16 raw request lines into a pending register.
//  - Applies a per-line mask and picks the lowest-index pending line (bit 0 highest priority).
//  - Presents the pick as a strict one-hot word plus its 4-bit index through a valid/ready slot.
//  - The one-hot output is always exactly one-hot when valid, so the downstream encoder never sees its default/X case.
// PARAMETERS
//  NREQ       16  number of request lines (block is verified at 16 only)
//  IW         4   index width; must equal clog2(NREQ)
//  EDGE_MODE  1   1: rising edge of req_in sets pending; 0: level-high sets pending every cycle
// PORTS
//  clk         in   1     single clock, all state updates on rising edge
//  rst         in   1     synchronous, active-high reset
//  req_in      in   NREQ  raw request lines, synchronous to clk
//  mask        in   NREQ  1 = line blocked from selection (still captured into pending)
//  clr_ovf     in   1     1-cycle pulse, clears ovf
//  onehot_out  out  NREQ  selected line, one-hot; 0 when !valid
//  idx_out     out  IW    index of selected line; 0 when !valid
//  valid       out  1     output slot holds a selection
//  ready       in   1     consumer accepts slot when valid && ready at a rising edge
//  ovf         out  NREQ  sticky: new event arrived on a line already pending
// BEHAVIOUR
//  Reset (rst=1 at edge): req_q, pending, ovf, valid, onehot_out, idx_out all <= 0.
//   - req_q=0 means a line held high across reset exit registers as an event on the first edge after reset.
//   - Reset mid-operation discards pending and the slot content without a handshake.
//  Capture, per edge:
//   - evt = EDGE_MODE ? (req_in & ~req_q) : req_in
//   - req_q <= req_in
//   - pending <= (pending & ~take) | evt
//   - Set wins: evt on a bit being taken the same cycle leaves that bit pending, with no ovf.
//  Overflow:
//   - ovf[i] <= 1 when evt[i] && pending[i] && !take[i].
//   - clr_ovf clears all ovf bits; a simultaneous set wins for that bit.
//   - In level mode ovf saturates while a line stays high; this is expected.
//  Selection (combinational, from registered pending/mask):
//   - cand = pending & ~mask
//   - pick = lowest set bit of cand
//   - load = |cand && (!valid || ready)
//   - take = load ? pick : 0
//  Output slot (registered):
//   - load: valid<=1, onehot_out<=pick, idx_out<=binary(pick).
//   - valid && ready && !load: valid<=0, onehot_out<=0, idx_out<=0.
//   - valid && !ready: all outputs held stable; no new load.
//   - Back-to-back: accept and new load occur on the same edge, so valid stays high and throughput is 1/cycle.
//  Latency: event sampled at edge E0 sets pending at E0; slot loads at E1 (empty slot), so valid=1 after E1.
//  Masking:
//   - A masked pending bit is retained, never presented, and is presented on unmask.
//   - Masking a line already in the slot does not revoke it.
//   - Bit selection depends only on pending & ~mask, not on the slot content, because taken bits are cleared at load.
//  Invariant: valid=1 implies $onehot(onehot_out) and onehot_out[idx_out]=1.
// TESTING
//  T1 reset: req_in=16'hFFFF held through rst -> first edge after rst sets pending=FFFF; valid at next edge, idx_out=0, onehot_out=16'h0001.
//  T2 priority drain: pending 16'h8421, ready=1 -> idx_out sequence 0,5,10,15 on consecutive cycles; valid drops after the 4th accept.
//  T3 backpressure: ready=0 while 16'h0006 pending -> onehot_out=16'h0002 and idx_out=1 held stable; ready=1 -> next cycle idx_out=2.
//  T4 mask: pending 16'h0003 with mask=16'h0001 -> idx_out=1 only; clear mask -> idx_out=0 presented; pending bits never lost.
//  T5 overflow: edge on line 7 while bit 7 pending and slot busy -> ovf=16'h0080; clr_ovf pulse -> ovf=0; edge coinciding with take -> re-pended, no ovf.
//  T6 mid-op reset: rst asserted with valid=1 and pending=16'h00F0 -> next cycle valid=0, pending=0, outputs 0; checker asserts the one-hot invariant every cycle.

Source files
------------

// File: rtl/irq_pend_arbiter.sv
// Captures request events into a pending set and presents the lowest-index unmasked line as one-hot + index.
// Latency: event at edge E0 pends at E0 and loads the slot at E1. Backpressure: slot holds while valid && !ready.
module irq_pend_arbiter #(
    parameter int NREQ      = 16,
    parameter int IW        = 4,
    parameter int EDGE_MODE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_in,
    input  logic [NREQ-1:0] mask,
    input  logic            clr_ovf,
    output logic [NREQ-1:0] onehot_out,
    output logic [IW-1:0]   idx_out,
    output logic            valid,
    input  logic            ready,
    output logic [NREQ-1:0] ovf
);

    logic [NREQ-1:0] req_q, req_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [NREQ-1:0] ovf_q, ovf_d;
    logic [NREQ-1:0] onehot_q, onehot_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            valid_q, valid_d;

    logic [NREQ-1:0] evt;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] take;
    logic [IW-1:0]   pick_idx;
    logic            load;

    always_comb begin
        evt  = (EDGE_MODE != 0) ? (req_in & ~req_q) : req_in;
        cand = pending_q & ~mask;
        // Two's-complement trick isolates the lowest set bit, so pick is one-hot by construction.
        pick = cand & (~cand + NREQ'(1));

        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_idx = IW'(i);
            end
        end

        load = (|cand) && (!valid_q || ready);
        take = load ? pick : '0;

        req_d     = req_in;
        // A new event on a bit being taken this cycle re-pends it rather than counting as overflow.
        pending_d = (pending_q & ~take) | evt;
        ovf_d     = (clr_ovf ? '0 : ovf_q) | (evt & pending_q & ~take);

        valid_d  = valid_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        if (load) begin
            valid_d  = 1'b1;
            onehot_d = pick;
            idx_d    = pick_idx;
        end else if (valid_q && ready) begin
            valid_d  = 1'b0;
            onehot_d = '0;
            idx_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            valid_q   <= 1'b0;
            onehot_q  <= '0;
            idx_q     <= '0;
        end else begin
            req_q     <= req_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            onehot_q  <= onehot_d;
            idx_q     <= idx_d;
        end
    end

    assign onehot_out = onehot_q;
    assign idx_out    = idx_q;
    assign valid      = valid_q;
    assign ovf        = ovf_q;

endmodule
